lsu_pipelined: RTL and testbench

- Parametrised load/store unit between the EX stage and data memory. Replaces the hard-wired single-access memEn/memWrEn control with a queued, handshaked interface.
- Buffers up to DEPTH memory requests and issues them in order, at most one per cycle.
- Tracks in-flight loads across a fixed memory read latency and produces register-file writeback.
- Exports a load-use hazard signal for the hazard detection unit.

---
 rtl/lsu_pipelined.sv | 145 ++++++++++++++
 tb/tb_lsu_pipelined.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipelined.sv
// In-order load/store unit: buffers EX-stage requests, issues one per cycle to data
// memory, tracks loads across the fixed read latency and drives register writeback.
module lsu_pipelined #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int RF_AW   = 5,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [RF_AW-1:0]    req_rd,
    input  logic [2:0]          req_ppp,
    output logic                mem_en,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_valid,
    output logic [RF_AW-1:0]    wb_rd,
    output logic [2:0]          wb_ppp,
    output logic [DATA_W-1:0]   wb_data,
    input  logic [RF_AW-1:0]    qry_ra,
    input  logic [RF_AW-1:0]    qry_rb,
    output logic                load_hazard,
    output logic                idle
);
    localparam int BE_W = DATA_W / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [RF_AW-1:0]  rd;
        logic [2:0]        ppp;
    } req_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // request side holds fields stable while waiting, and mem_* stays stable
    // while mem_en && !mem_ready.
    req_t             q_mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, count;
    logic             q_empty, push, pop, ld_acc;
    req_t             head;

    logic [MEM_LAT-1:0] trk_v;
    logic [RF_AW-1:0]   trk_rd  [MEM_LAT];
    logic [2:0]         trk_ppp [MEM_LAT];

    function automatic logic rd_hit(input logic [RF_AW-1:0] rd,
                                    input logic [RF_AW-1:0] ra,
                                    input logic [RF_AW-1:0] rb);
        return ((ra != '0) && (rd == ra)) || ((rb != '0) && (rd == rb));
    endfunction

    assign count     = wr_ptr - rd_ptr;
    assign q_empty   = (count == '0);
    assign req_ready = reset && (count < PW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = q_mem[rd_ptr[AW-1:0]];
    assign pop       = !q_empty && mem_ready;
    assign ld_acc    = pop && !head.we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: entries are only observed inside the valid window.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr[AW-1:0]] <= {req_we, req_addr, req_wdata, req_be, req_rd, req_ppp};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            trk_v <= '0;
        end else begin
            trk_v[0] <= ld_acc;
            for (int i = 1; i < MEM_LAT; i++) trk_v[i] <= trk_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        trk_rd[0]  <= head.rd;
        trk_ppp[0] <= head.ppp;
        for (int i = 1; i < MEM_LAT; i++) begin
            trk_rd[i]  <= trk_rd[i-1];
            trk_ppp[i] <= trk_ppp[i-1];
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!q_empty) begin
            mem_en    = 1'b1;
            mem_wr_en = head.we;
            mem_addr  = head.addr;
            mem_wdata = head.we ? head.wdata : '0;
            mem_be    = head.we ? head.be : '1;
        end
    end

    assign wb_valid = trk_v[MEM_LAT-1];
    assign wb_rd    = wb_valid ? trk_rd[MEM_LAT-1] : '0;
    assign wb_ppp   = wb_valid ? trk_ppp[MEM_LAT-1] : '0;
    assign wb_data  = wb_valid ? mem_rdata : '0;

    // A load is a hazard from enqueue until (and including) its writeback cycle.
    always_comb begin
        logic [AW-1:0] idx;
        idx         = '0;
        load_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr[AW-1:0] + AW'(k);
            if ((PW'(k) < count) && !q_mem[idx].we && rd_hit(q_mem[idx].rd, qry_ra, qry_rb))
                load_hazard = 1'b1;
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            if (trk_v[i] && rd_hit(trk_rd[i], qry_ra, qry_rb)) load_hazard = 1'b1;
        end
    end

    assign idle = q_empty && (trk_v == '0);

endmodule

// File: tb/tb_lsu_pipelined.sv
// Randomised and directed bench for lsu_pipelined against a program-order reference
// model with a behavioural fixed-latency memory.
module tb_lsu_pipelined;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 32;
    localparam int RF_AW   = 5;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 2;
    localparam int BE_W    = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic [RF_AW-1:0]  req_rd;
    logic [2:0]        req_ppp;
    logic              mem_en, mem_wr_en, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [BE_W-1:0]   mem_be;
    logic              wb_valid;
    logic [RF_AW-1:0]  wb_rd;
    logic [2:0]        wb_ppp;
    logic [DATA_W-1:0] wb_data;
    logic [RF_AW-1:0]  qry_ra, qry_rb;
    logic              load_hazard, idle;

    lsu_pipelined #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RF_AW(RF_AW), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_rd(req_rd), .req_ppp(req_ppp),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ppp(wb_ppp), .wb_data(wb_data),
        .qry_ra(qry_ra), .qry_rb(qry_rb), .load_hazard(load_hazard), .idle(idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [RF_AW-1:0]  rd;
        logic [2:0]        ppp;
        logic [DATA_W-1:0] ldata;
    } req_s;
    typedef struct {
        int                cyc;
        logic [RF_AW-1:0]  rd;
        logic [2:0]        ppp;
        logic [DATA_W-1:0] data;
    } wb_s;
    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } rsp_s;

    // reference model: program-order queue, expected writebacks, pending load targets
    req_s              iss_q[$];
    wb_s               exp_q[$];
    rsp_s              rsp_q[$];
    logic [RF_AW-1:0]  pend[$];
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] phys_mem[logic [ADDR_W-1:0]];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int rdy_hold = 0;
    bit rnd_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic bit hazard_exp();
        foreach (pend[i]) begin
            if ((qry_ra != 0 && pend[i] == qry_ra) || (qry_rb != 0 && pend[i] == qry_rb)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // one clock: drive memory side, check mid-cycle, then advance the model at the edge
    task automatic step();
        req_s h;
        wb_s  w;
        bit   en, push, pop;
        logic [DATA_W-1:0] pv;
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) void'(rsp_q.pop_front());
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) mem_rdata = rsp_q[0].data;
        else mem_rdata = {$urandom, $urandom};
        if (rdy_hold > 0) begin
            mem_ready = 1'b0;
            rdy_hold--;
        end else begin
            mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #2;
        en = (iss_q.size() > 0);
        if (en) h = iss_q[0];
        else h = '{default: '0};
        if (chk_en) begin
            check_eq("req_ready", req_ready, reset && (iss_q.size() < DEPTH));
            check_eq("mem_en", mem_en, en);
            check_eq("mem_wr_en", mem_wr_en, en && h.we);
            check_eq("mem_addr", mem_addr, en ? h.addr : '0);
            check_eq("mem_wdata", mem_wdata, (en && h.we) ? h.wdata : '0);
            check_eq("mem_be", mem_be, !en ? 8'h00 : (h.we ? h.be : 8'hFF));
            check_eq("load_hazard", load_hazard, hazard_exp());
            check_eq("idle", idle, (iss_q.size() == 0) && (pend.size() == 0));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                w = exp_q.pop_front();
                check_eq("wb_valid", wb_valid, 1'b1);
                check_eq("wb_rd", wb_rd, w.rd);
                check_eq("wb_ppp", wb_ppp, w.ppp);
                check_eq("wb_data", wb_data, w.data);
                foreach (pend[i]) if (pend[i] == w.rd) begin pend.delete(i); break; end
            end else begin
                check_eq("wb_valid_idle", wb_valid, 1'b0);
                check_eq("wb_fields_idle", {wb_rd, wb_ppp}, '0);
                check_eq("wb_data_idle", wb_data, '0);
            end
        end
        push = reset && req_valid && (iss_q.size() < DEPTH);
        pop  = en && mem_ready;
        @(posedge clk);
        #1;
        if (pop) begin
            pv = phys_mem.exists(h.addr) ? phys_mem[h.addr] : '0;
            if (h.we) phys_mem[h.addr] = merge(pv, h.wdata, h.be);
            else rsp_q.push_back('{cyc: cyc + MEM_LAT, data: pv});
        end
        if (!reset) begin
            iss_q.delete();
            exp_q.delete();
            pend.delete();
            ref_mem = phys_mem;
            chk_en = 1'b1;
        end else begin
            if (pop) begin
                void'(iss_q.pop_front());
                if (!h.we) exp_q.push_back('{cyc: cyc + MEM_LAT, rd: h.rd, ppp: h.ppp, data: h.ldata});
            end
            if (push) begin
                req_s n;
                n.we = req_we; n.addr = req_addr; n.wdata = req_wdata; n.be = req_be;
                n.rd = req_rd; n.ppp = req_ppp; n.ldata = '0;
                pv = ref_mem.exists(req_addr) ? ref_mem[req_addr] : '0;
                if (req_we) ref_mem[req_addr] = merge(pv, req_wdata, req_be);
                else begin
                    n.ldata = pv;
                    pend.push_back(req_rd);
                end
                iss_q.push_back(n);
            end
        end
        cyc++;
    endtask

    // driver: offer one request and hold it until the queue takes it (bounded)
    task automatic send(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [BE_W-1:0] be, input logic [RF_AW-1:0] rd, input logic [2:0] ppp);
        bit acc;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        req_be = be; req_rd = rd; req_ppp = ppp;
        for (int t = 0; t < 50; t++) begin
            acc = reset && (iss_q.size() < DEPTH);
            step();
            if (acc) break;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        req_rd = '0; req_ppp = '0; mem_ready = 1'b1; mem_rdata = '0; qry_ra = '0; qry_rb = '0;

        // reset held with a request offered
        reset = 1'b0;
        repeat (3) step();
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) step();

        // single load with hazard query on its destination
        qry_ra = 5'd3; qry_rb = 5'd0;
        send(1'b0, 32'h10, '0, '0, 5'd3, 3'b101);
        repeat (5) step();

        // backpressure: memory stalls while five loads are offered
        rdy_hold = 8;
        for (int i = 0; i < 5; i++) send(1'b0, 32'(i * 8), '0, '0, 5'(i + 1), 3'(i));
        repeat (6) step();

        // store then load from the same address
        qry_ra = 5'd1; qry_rb = 5'd0;
        send(1'b1, 32'h20, 64'hDEADBEEF00000000, 8'hF0, 5'd1, 3'd0);
        repeat (3) step();
        send(1'b0, 32'h20, '0, '0, 5'd2, 3'd6);
        repeat (4) step();

        // streaming with pointer wrap
        qry_ra = 5'd7; qry_rb = 5'd10;
        for (int r = 1; r <= 10; r++) send(1'b0, 32'(r * 8), '0, '0, 5'(r), 3'(r));
        repeat (6) step();

        // reset with loads in flight and queued
        send(1'b0, 32'h08, '0, '0, 5'd4, 3'd1);
        send(1'b0, 32'h10, '0, '0, 5'd5, 3'd2);
        rdy_hold = 4;
        send(1'b0, 32'h18, '0, '0, 5'd6, 3'd3);
        send(1'b0, 32'h20, '0, '0, 5'd4, 3'd4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (6) step();

        // randomised traffic
        rnd_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 2) == 0);
            req_addr  = 32'($urandom_range(0, 7) * 8);
            req_wdata = {$urandom, $urandom};
            req_be    = 8'($urandom_range(0, 255));
            req_rd    = 5'($urandom_range(0, 7));
            req_ppp   = 3'($urandom_range(0, 7));
            qry_ra    = 5'($urandom_range(0, 7));
            qry_rb    = 5'($urandom_range(0, 7));
            step();
        end
        req_valid = 1'b0;
        rnd_ready = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
